ddr2_cmd_issuer: RTL and testbench

DDR2_CMD_ISSUER -- requirements
Module: ddr2_cmd_issuer

---
 rtl/ddr2_cmd_issuer.sv | 185 ++++++++++++++++++
 tb/tb_ddr2_cmd_issuer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_issuer.sv
// Single-request DDR2 command sequencer: ACT -> RD/WR with auto-precharge -> done,
// with a free-running refresh timer whose REF takes priority over new requests in IDLE.
module ddr2_cmd_issuer #(
  parameter int T_RCD   = 4,
  parameter int T_RWREC = 12,
  parameter int T_RFC   = 28,
  parameter int T_REFI  = 2080
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_ba,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  output logic        req_done,
  output logic        cke,
  output logic        csbar,
  output logic        rasbar,
  output logic        casbar,
  output logic        webar,
  output logic [1:0]  ba,
  output logic [12:0] a,
  output logic        ref_busy,
  output logic [2:0]  state_dbg,
  output logic        ref_pending_dbg
);

  localparam int MAX_AB   = (T_RCD > T_RWREC) ? T_RCD : T_RWREC;
  localparam int MAX_WAIT = (MAX_AB > T_RFC) ? MAX_AB : T_RFC;
  localparam int WCW      = $clog2(MAX_WAIT) + 1;
  localparam int RCW      = $clog2(T_REFI) + 1;

  // Each wait state is preceded by one command cycle, so it lasts T-1 cycles.
  localparam logic [WCW-1:0] RCD_LOAD   = WCW'(T_RCD - 2);
  localparam logic [WCW-1:0] RWREC_LOAD = WCW'(T_RWREC - 2);
  localparam logic [WCW-1:0] RFC_LOAD   = WCW'(T_RFC - 2);
  localparam logic [RCW-1:0] REFI_LOAD  = RCW'(T_REFI - 1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_DES = 4'b1111;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACT       = 3'd1,
    WAIT_RCD  = 3'd2,
    RW        = 3'd3,
    WAIT_DONE = 3'd4,
    REF       = 3'd5,
    WAIT_RFC  = 3'd6
  } state_t;

  state_t           state, next_state;
  logic [WCW-1:0]   wcnt, wcnt_next;
  logic [RCW-1:0]   ref_cnt;
  logic             ref_pending, ref_pending_next;
  logic             ref_expire, accept;

  logic             cap_write;
  logic [1:0]       cap_ba;
  logic [9:0]       cap_col;

  logic [3:0]       cmd_q, cmd_next;
  logic [1:0]       ba_next;
  logic [12:0]      a_next;
  logic             req_ready_next, req_done_next, ref_busy_next;

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; req_ready is registered and only asserts in IDLE with no refresh due.
  assign accept     = req_valid && req_ready;
  assign ref_expire = (ref_cnt == '0);

  always_comb begin
    next_state = state;
    wcnt_next  = wcnt;
    unique case (state)
      IDLE: begin
        if (ref_pending)  next_state = REF;
        else if (accept)  next_state = ACT;
      end
      ACT: begin
        next_state = WAIT_RCD;
        wcnt_next  = RCD_LOAD;
      end
      WAIT_RCD: begin
        if (wcnt == '0) next_state = RW;
        else            wcnt_next  = wcnt - WCW'(1);
      end
      RW: begin
        next_state = WAIT_DONE;
        wcnt_next  = RWREC_LOAD;
      end
      WAIT_DONE: begin
        if (wcnt == '0) next_state = IDLE;
        else            wcnt_next  = wcnt - WCW'(1);
      end
      REF: begin
        next_state = WAIT_RFC;
        wcnt_next  = RFC_LOAD;
      end
      WAIT_RFC: begin
        if (wcnt == '0) next_state = IDLE;
        else            wcnt_next  = wcnt - WCW'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  // A fresh expiry in the same cycle the pending refresh is issued is a new interval, so keep it.
  always_comb begin
    ref_pending_next = ref_expire || (ref_pending && !(state == IDLE));
    if (state != IDLE) ref_pending_next = ref_expire || ref_pending;
  end

  always_comb begin
    cmd_next = CMD_NOP;
    ba_next  = 2'b00;
    a_next   = 13'd0;
    unique case (next_state)
      ACT: begin
        cmd_next = CMD_ACT;
        ba_next  = req_ba;
        a_next   = req_row;
      end
      RW: begin
        cmd_next = cap_write ? CMD_WR : CMD_RD;
        ba_next  = cap_ba;
        a_next   = {2'b00, 1'b1, cap_col};
      end
      REF: cmd_next = CMD_REF;
      default: cmd_next = CMD_NOP;
    endcase
  end

  // Done is flagged in the first IDLE cycle; ready follows one cycle later.
  assign req_done_next  = (state == WAIT_DONE) && (next_state == IDLE);
  assign ref_busy_next  = (next_state == REF) || (next_state == WAIT_RFC);
  assign req_ready_next = (state == IDLE) && (next_state == IDLE) && !ref_pending_next;

  always_ff @(posedge ck) begin
    if (reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      ref_cnt     <= REFI_LOAD;
      ref_pending <= 1'b0;
      cap_write   <= 1'b0;
      cap_ba      <= 2'b00;
      cap_col     <= 10'd0;
      cke         <= 1'b0;
      cmd_q       <= CMD_DES;
      ba          <= 2'b00;
      a           <= 13'd0;
      req_ready   <= 1'b0;
      req_done    <= 1'b0;
      ref_busy    <= 1'b0;
    end else begin
      state       <= next_state;
      wcnt        <= wcnt_next;
      ref_cnt     <= ref_expire ? REFI_LOAD : (ref_cnt - RCW'(1));
      ref_pending <= ref_pending_next;
      if (accept && state == IDLE && !ref_pending) begin
        cap_write <= req_write;
        cap_ba    <= req_ba;
        cap_col   <= req_col;
      end
      cke         <= 1'b1;
      cmd_q       <= cmd_next;
      ba          <= ba_next;
      a           <= a_next;
      req_ready   <= req_ready_next;
      req_done    <= req_done_next;
      ref_busy    <= ref_busy_next;
    end
  end

  assign {csbar, rasbar, casbar, webar} = cmd_q;
  assign state_dbg       = state;
  assign ref_pending_dbg = ref_pending;

endmodule

// File: tb/tb_ddr2_cmd_issuer.sv
// Bench for ddr2_cmd_issuer: table-driven requests plus directed refresh and reset
// sequences, with every command and req_done pulse matched against an expected queue.
module tb_ddr2_cmd_issuer;

  localparam int T_RCD   = 4;
  localparam int T_RWREC = 12;
  localparam int T_RFC   = 28;
  localparam int T_REFI  = 2080;
  localparam int EW      = 36;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_DES = 4'b1111;

  typedef struct {
    logic        wr;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [9:0]  col;
    logic [3:0]  exp_cmd;
    logic [12:0] exp_a;
  } vec_t;

  logic        ck, reset, req_valid, req_ready, req_write, req_done;
  logic [1:0]  req_ba, ba;
  logic [12:0] req_row, a;
  logic [9:0]  req_col;
  logic        cke, csbar, rasbar, casbar, webar, ref_busy, ref_pending_dbg;
  logic [2:0]  state_dbg;

  ddr2_cmd_issuer #(.T_RCD(T_RCD), .T_RWREC(T_RWREC), .T_RFC(T_RFC), .T_REFI(T_REFI)) dut (
    .ck(ck), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .req_done(req_done), .cke(cke), .csbar(csbar), .rasbar(rasbar), .casbar(casbar),
    .webar(webar), .ba(ba), .a(a), .ref_busy(ref_busy), .state_dbg(state_dbg),
    .ref_pending_dbg(ref_pending_dbg)
  );

  // Clock and cycle index (cycle 1 = first cycle after reset is released)
  initial ck = 1'b0;
  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] mk_ev(input int c, input logic d, input logic [3:0] cm,
                                          input logic [1:0] b, input logic [12:0] ad);
    return {16'(c), d, cm, b, ad};
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor plus ACT->RD/WR and REF->command spacing checker
  int last_act = -1000;
  int last_ref = -1000;
  always @(negedge ck) begin
    logic [3:0]    cm;
    logic [EW-1:0] got, want;
    cm = {csbar, rasbar, casbar, webar};
    if (cyc == 0) begin
      last_act = -1000;
      last_ref = -1000;
    end else if (cke === 1'b1 && ((cm !== C_NOP && cm !== C_DES) || req_done === 1'b1)) begin
      got = mk_ev(cyc, req_done, cm, ba, a);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL event actual=%h required=%h", got, want);
        end
      end
      if (cm == C_RD || cm == C_WR) begin
        checks++;
        if (cyc - last_act != T_RCD) begin
          errors++;
          $display("FAIL rcd_gap actual=%0d required=%0d", cyc - last_act, T_RCD);
        end
      end
      if (cm != C_NOP && last_ref >= 0) begin
        checks++;
        if (cyc - last_ref < T_RFC) begin
          errors++;
          $display("FAIL rfc_gap actual=%0d required>=%0d", cyc - last_ref, T_RFC);
        end
      end
      if (cm == C_ACT) last_act = cyc;
      if (cm == C_REF) last_ref = cyc;
    end
  end

  // Driver: called at a negedge, returns at the negedge after acceptance.
  task automatic do_req(input vec_t v, input bit hold, input bit full, output int n);
    int t;
    req_write = v.wr;
    req_ba    = v.ba;
    req_row   = v.row;
    req_col   = v.col;
    req_valid = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 400) begin
      @(negedge ck);
      t++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
      req_valid = 1'b0;
      n = -1;
      return;
    end
    n = cyc;
    exp_q.push_back(mk_ev(n + 1, 1'b0, C_ACT, v.ba, v.row));
    if (full) begin
      exp_q.push_back(mk_ev(n + 1 + T_RCD, 1'b0, v.exp_cmd, v.ba, v.exp_a));
      exp_q.push_back(mk_ev(n + 1 + T_RCD + T_RWREC, 1'b1, C_NOP, 2'b00, 13'd0));
    end
    @(negedge ck);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int t;
    t = 0;
    while (cyc != target && t < 10000) begin
      @(negedge ck);
      t++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout actual=%0d required=%0d", cyc, target);
    end
  endtask

  vec_t tbl[7];
  initial begin
    vec_t v;
    int   n, prev_n, busy_n, ready_n;

    tbl[0] = '{1'b0, 2'd2, 13'h1ABC, 10'h155, C_RD, 13'h0555};
    tbl[1] = '{1'b1, 2'd2, 13'h1ABC, 10'h155, C_WR, 13'h0555};
    tbl[2] = '{1'b0, 2'd0, 13'h0000, 10'h000, C_RD, 13'h0400};
    tbl[3] = '{1'b1, 2'd3, 13'h1FFF, 10'h3FF, C_WR, 13'h07FF};
    tbl[4] = '{1'b0, 2'd1, 13'h0AAA, 10'h2AA, C_RD, 13'h06AA};
    tbl[5] = '{1'b1, 2'd0, 13'h1555, 10'h001, C_WR, 13'h0401};
    tbl[6] = '{1'b0, 2'd3, 13'h0001, 10'h200, C_RD, 13'h0600};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_ba = 2'b00; req_row = 13'd0; req_col = 10'd0;
    repeat (3) @(negedge ck);
    check("rst_cke", cke, 0);
    check("rst_pins", {csbar, rasbar, casbar, webar}, C_DES);
    check("rst_ba", ba, 0);
    check("rst_a", a, 0);
    check("rst_ready", req_ready, 0);
    check("rst_done", req_done, 0);
    check("rst_busy", ref_busy, 0);
    check("rst_state", state_dbg, 0);
    check("rst_pending", ref_pending_dbg, 0);

    reset = 1'b0;
    @(negedge ck);
    check("first_cke", cke, 1);
    check("first_pins", {csbar, rasbar, casbar, webar}, C_NOP);
    check("first_ready", req_ready, 1);

    // Refresh in idle: REF at cycle 2081, ref_busy for T_RFC cycles
    exp_q.push_back(mk_ev(2081, 1'b0, C_REF, 2'b00, 13'd0));
    wait_cyc(2079);
    check("ready_before_ref", req_ready, 1);
    @(negedge ck);
    check("ready_ref_pending", req_ready, 0);
    check("pending_set", ref_pending_dbg, 1);
    busy_n = 0;
    ready_n = 0;
    for (int i = 0; i < 29; i++) begin
      @(negedge ck);
      if (ref_busy === 1'b1) busy_n++;
      if (req_ready === 1'b1) ready_n++;
    end
    check("ref_busy_len", busy_n, T_RFC);
    check("ready_during_ref", ready_n, 0);
    @(negedge ck);
    check("ready_after_ref", req_ready, 1);

    // Table: entry 0 holds req_valid so entry 1 is accepted back-to-back
    prev_n = 0;
    for (int i = 0; i < 7; i++) begin
      do_req(tbl[i], (i == 0), 1'b1, n);
      if (i == 1) check("b2b_gap", n - prev_n, 18);
      prev_n = n;
    end
    for (int i = 0; i < 4; i++) begin
      v.wr      = 1'($urandom_range(0, 1));
      v.ba      = 2'($urandom_range(0, 3));
      v.row     = 13'($urandom_range(0, 8191));
      v.col     = 10'($urandom_range(0, 1023));
      v.exp_cmd = v.wr ? C_WR : C_RD;
      v.exp_a   = {2'b00, 1'b1, v.col};
      do_req(v, 1'b0, 1'b1, n);
    end

    // Refresh expiring mid-request (pending at 4160): REF one cycle after req_done
    wait_cyc(4150);
    do_req(tbl[0], 1'b0, 1'b1, n);
    check("accept_4150", n, 4150);
    exp_q.push_back(mk_ev(4168, 1'b0, C_REF, 2'b00, 13'd0));

    // Request rising in the cycle ref_pending sets (6240): REF goes first
    wait_cyc(6240);
    check("ready_at_expiry", req_ready, 0);
    exp_q.push_back(mk_ev(6241, 1'b0, C_REF, 2'b00, 13'd0));
    do_req(tbl[1], 1'b0, 1'b1, n);
    check("accept_after_ref", n, 6241 + T_RFC + 1);

    // Reset during WAIT_RCD: no RD, no req_done
    wait_cyc(6295);
    do_req(tbl[2], 1'b0, 1'b0, n);
    @(negedge ck);
    check("in_wait_rcd", state_dbg, 2);
    reset = 1'b1;
    @(negedge ck);
    check("midrst_cke", cke, 0);
    check("midrst_pins", {csbar, rasbar, casbar, webar}, C_DES);
    check("midrst_ready", req_ready, 0);
    check("midrst_done", req_done, 0);
    reset = 1'b0;
    @(negedge ck);
    check("postrst_cke", cke, 1);
    check("postrst_pins", {csbar, rasbar, casbar, webar}, C_NOP);
    check("postrst_ready", req_ready, 1);
    repeat (30) @(negedge ck);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
